// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// default PC / fetch-window values and small PC helpers.
package ifu_fetch_pkg;

    // Fetch FSM states, 3-bit encoding
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DROP  = 3'd4
    } fetch_state_t;

    // Architectural PC after reset and the legal instruction-memory window
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_IMEM_BASE  = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_IMEM_BYTES = 32'h0000_4000;

    // Instruction word handed to decode when the fetch address is illegal
    localparam logic [31:0] NOP = 32'h0000_0000;

    // Sequential successor of a PC; wraps modulo 2^32
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Bundles the fetch stage's three conversations: redirects from next-PC
// logic, the instruction-memory read port and the hand-off to decode.
// The master modport is the fetch unit's view, slave is everyone else's.
interface ifu_fetch_if;

    logic        redirect;
    logic [31:0] redirect_pc;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_4;
    logic        if_exc_adel;

    modport master (
        input  redirect, redirect_pc,
        input  imem_rvalid, imem_rdata,
        input  if_ready,
        output imem_req, imem_addr,
        output if_valid, if_instr, if_pc, if_pc_4, if_exc_adel
    );

    modport slave (
        output redirect, redirect_pc,
        output imem_rvalid, imem_rdata,
        output if_ready,
        input  imem_req, imem_addr,
        input  if_valid, if_instr, if_pc, if_pc_4, if_exc_adel
    );

endinterface

// File: rtl/ifu_addr_check.sv
// Combinational address-legality check: flags a word access that is
// misaligned or falls outside [BASE, BASE+BYTES). Written generically so
// the data-memory stage can reuse it with its own window.
module ifu_addr_check
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] BASE  = DEFAULT_IMEM_BASE,
    parameter logic [31:0] BYTES = DEFAULT_IMEM_BYTES
) (
    input  logic [31:0] addr,
    output logic        bad
);

    // Upper bound is exclusive and computed in 32-bit wrapping arithmetic
    localparam logic [31:0] LIMIT = BASE + BYTES;

    // Misaligned, below the window, or at/above its end
    always_comb begin
        bad = (addr[1:0] != 2'b00) || (addr < BASE) || (addr >= LIMIT);
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage. Owns the architectural PC, issues one
// instruction-memory read at a time and hands the fetched word (or an
// address-error marker) to decode over a valid/ready handshake. Redirects
// from next-PC logic override everything, including a pending handshake.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] IMEM_BASE  = DEFAULT_IMEM_BASE,
    parameter logic [31:0] IMEM_BYTES = DEFAULT_IMEM_BYTES
) (
    input logic         clk,
    input logic         rst_n,
    ifu_fetch_if.master bus
);

    fetch_state_t state;
    fetch_state_t state_next;

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        pc_bad;

    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    logic [31:0] hold_pc_4;
    logic        hold_exc;

    logic        load_hold;
    logic [31:0] load_instr;
    logic        load_exc;
    logic        req;

    ifu_addr_check #(
        .BASE  (IMEM_BASE),
        .BYTES (IMEM_BYTES)
    ) u_addr_check (
        .addr (pc),
        .bad  (pc_bad)
    );

    // A request goes out only from ISSUE and only for a legal address
    always_comb begin
        req = (state == S_ISSUE) && !pc_bad;
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc;
    assign bus.if_valid    = (state == S_HOLD);
    assign bus.if_instr    = hold_instr;
    assign bus.if_pc       = hold_pc;
    assign bus.if_pc_4     = hold_pc_4;
    assign bus.if_exc_adel = hold_exc;

    // Next-state, next-PC and hold-register load decisions
    always_comb begin
        state_next = state;
        pc_next    = pc;
        load_hold  = 1'b0;
        load_instr = NOP;
        load_exc   = 1'b0;

        case (state)
            S_IDLE: begin
                state_next = S_ISSUE;
            end

            S_ISSUE: begin
                if (bus.redirect) begin
                    // A request issued this cycle must have its response dropped
                    pc_next    = bus.redirect_pc;
                    state_next = req ? S_DROP : S_ISSUE;
                end else if (pc_bad) begin
                    load_hold  = 1'b1;
                    load_instr = NOP;
                    load_exc   = 1'b1;
                    state_next = S_HOLD;
                end else begin
                    state_next = S_WAIT;
                end
            end

            S_WAIT: begin
                if (bus.redirect) begin
                    pc_next    = bus.redirect_pc;
                    state_next = bus.imem_rvalid ? S_ISSUE : S_DROP;
                end else if (bus.imem_rvalid) begin
                    load_hold  = 1'b1;
                    load_instr = bus.imem_rdata;
                    load_exc   = 1'b0;
                    state_next = S_HOLD;
                end
            end

            S_HOLD: begin
                if (bus.redirect) begin
                    // No delay slot: the held instruction is thrown away
                    pc_next    = bus.redirect_pc;
                    state_next = S_ISSUE;
                end else if (bus.if_ready) begin
                    pc_next    = pc_plus4(pc);
                    state_next = S_ISSUE;
                end
            end

            S_DROP: begin
                if (bus.redirect) begin
                    pc_next = bus.redirect_pc;
                end
                if (bus.imem_rvalid) begin
                    state_next = S_ISSUE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and PC registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Decode-facing hold registers, loaded when an instruction is captured
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_instr <= NOP;
            hold_pc    <= RESET_PC;
            hold_pc_4  <= pc_plus4(RESET_PC);
            hold_exc   <= 1'b0;
        end else if (load_hold) begin
            hold_instr <= load_instr;
            hold_pc    <= pc;
            hold_pc_4  <= pc_plus4(pc);
            hold_exc   <= load_exc;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch. One process drives everything: each
// tick waits for the falling edge, checks requests and new deliveries
// against scoreboard queues, then advances a simple memory model.
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_4;
        logic [31:0] instr;
        logic        exc;
    } fetch_rec_t;

    typedef struct {
        logic [31:0] redirect_pc;
        logic        exp_bad;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    ifu_fetch_if bus ();

    ifu_fetch #(
        .RESET_PC   (32'h0000_3000),
        .IMEM_BASE  (32'h0000_3000),
        .IMEM_BYTES (32'h0000_4000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    fetch_rec_t  exp_del[$];
    logic [31:0] exp_req[$];
    int          req_cycle_q[$];

    int          n_compared = 0;
    int          n_mismatch = 0;
    int          cycle      = 0;
    int          del_count  = 0;
    logic        prev_valid = 1'b0;

    int          mem_lat    = 1;
    bit          mem_enable = 1'b1;
    int          mem_cnt    = 0;
    logic [31:0] mem_addr   = 32'h0;
    logic [31:0] ovr_addr   = 32'h0000_0001;
    logic [31:0] ovr_data   = 32'h0;

    vec_t        vecs[7];

    // Memory contents: address-derived pattern unless overridden
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == ovr_addr) return ovr_data;
        return addr ^ 32'h5A5A_0000;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic ready);
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.if_ready    = ready;
    endtask

    task automatic push_fetch(input logic [31:0] pc, input logic bad);
        fetch_rec_t r;
        r.pc    = pc;
        r.pc_4  = pc + 32'd4;
        r.instr = bad ? 32'h0 : mem_word(pc);
        r.exc   = bad;
        if (!bad) exp_req.push_back(pc);
        exp_del.push_back(r);
    endtask

    // One clock: sample outputs, score them, then step the memory model
    task automatic tick();
        fetch_rec_t e;
        @(negedge clk);
        cycle++;
        if (bus.imem_req) begin
            req_cycle_q.push_back(cycle);
            if (exp_req.size() == 0) begin
                n_compared++;
                n_mismatch++;
                $display("[TB] FAIL unexpected_req: got request to %h required none (cycle %0d)", bus.imem_addr, cycle);
            end else begin
                checkOutput("imem_addr", bus.imem_addr, exp_req.pop_front());
            end
        end
        if (bus.if_valid && !prev_valid) begin
            del_count++;
            if (exp_del.size() == 0) begin
                n_compared++;
                n_mismatch++;
                $display("[TB] FAIL unexpected_delivery: got pc %h required none (cycle %0d)", bus.if_pc, cycle);
            end else begin
                e = exp_del.pop_front();
                checkOutput("if_pc", bus.if_pc, e.pc);
                checkOutput("if_pc_4", bus.if_pc_4, e.pc_4);
                checkOutput("if_instr", bus.if_instr, e.instr);
                checkOutput("if_exc_adel", 32'(bus.if_exc_adel), 32'(e.exc));
            end
        end
        prev_valid = bus.if_valid;
        if (mem_enable) begin
            bus.imem_rvalid = 1'b0;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem_word(mem_addr);
                end
            end
            if (bus.imem_req) begin
                mem_cnt  = mem_lat;
                mem_addr = bus.imem_addr;
            end
        end
    endtask

    // Run until n more instructions are presented, then stop accepting
    task automatic wait_deliveries(input int n);
        int target;
        target = del_count + n;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (del_count >= target) begin
                bus.if_ready = 1'b0;
                return;
            end
        end
        n_compared++;
        n_mismatch++;
        $display("[TB] FAIL wait_deliveries: got %0d deliveries required %0d", del_count, target);
        bus.if_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h0000_3002, 1'b1};
        vecs[1] = '{32'h0000_2FFC, 1'b1};
        vecs[2] = '{32'h0000_3100, 1'b0};
        vecs[3] = '{32'h0000_6FFC, 1'b0};
        vecs[4] = '{32'h0000_7000, 1'b1};
        vecs[5] = '{32'h0000_3001, 1'b1};
        vecs[6] = '{32'h0000_3000, 1'b0};

        rst_n           = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        applyStimulus(1'b0, 32'h0, 1'b0);

        // Reset values
        tick();
        tick();
        checkOutput("rst_imem_req", 32'(bus.imem_req), 32'd0);
        checkOutput("rst_if_valid", 32'(bus.if_valid), 32'd0);
        checkOutput("rst_imem_addr", bus.imem_addr, 32'h0000_3000);
        checkOutput("rst_if_instr", bus.if_instr, 32'h0);
        checkOutput("rst_if_pc", bus.if_pc, 32'h0000_3000);
        checkOutput("rst_if_pc_4", bus.if_pc_4, 32'h0000_3004);
        checkOutput("rst_if_exc", 32'(bus.if_exc_adel), 32'd0);

        // Streaming fetch, 1-cycle memory, decode always ready
        $display("[TB] sequential fetch");
        push_fetch(32'h0000_3000, 1'b0);
        push_fetch(32'h0000_3004, 1'b0);
        push_fetch(32'h0000_3008, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1);
        wait_deliveries(3);
        if (req_cycle_q.size() >= 3) begin
            checkOutput("req_gap_0", 32'(req_cycle_q[1] - req_cycle_q[0]), 32'd3);
            checkOutput("req_gap_1", 32'(req_cycle_q[2] - req_cycle_q[1]), 32'd3);
        end else begin
            checkOutput("req_count", 32'(req_cycle_q.size()), 32'd3);
        end

        // Backpressure: instruction must sit stable with no new request
        $display("[TB] backpressure");
        ovr_addr = 32'h0000_300C;
        ovr_data = 32'h3C01_1234;
        push_fetch(32'h0000_300C, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        wait_deliveries(1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_if_valid", 32'(bus.if_valid), 32'd1);
            checkOutput("bp_if_instr", bus.if_instr, 32'h3C01_1234);
            checkOutput("bp_if_pc", bus.if_pc, 32'h0000_300C);
            checkOutput("bp_imem_req", 32'(bus.imem_req), 32'd0);
        end
        push_fetch(32'h0000_3010, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        wait_deliveries(1);

        // Redirect and if_ready together in HOLD: redirect wins
        $display("[TB] redirect beats ready");
        push_fetch(32'h0000_3040, 1'b0);
        applyStimulus(1'b1, 32'h0000_3040, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        wait_deliveries(1);

        // Redirect while waiting on a slow memory: old response dropped
        $display("[TB] redirect in wait");
        mem_lat = 4;
        exp_req.push_back(32'h0000_3044);
        applyStimulus(1'b0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        tick();
        push_fetch(32'h0000_3100, 1'b0);
        applyStimulus(1'b1, 32'h0000_3100, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        wait_deliveries(1);
        mem_lat = 1;

        // Table of redirect targets, legal and illegal, taken from HOLD
        $display("[TB] redirect target table");
        for (int v = 0; v < 7; v++) begin
            push_fetch(vecs[v].redirect_pc, vecs[v].exp_bad);
            applyStimulus(1'b1, vecs[v].redirect_pc, 1'b0);
            tick();
            applyStimulus(1'b0, 32'h0, 1'b0);
            wait_deliveries(1);
        end

        // Top of the address space: pc+4 wraps to 0, which is also illegal
        $display("[TB] pc wrap");
        push_fetch(32'hFFFF_FFFC, 1'b1);
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        wait_deliveries(1);
        push_fetch(32'h0000_0000, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        wait_deliveries(1);

        // Reset while a request is outstanding; late response must be ignored
        $display("[TB] reset mid-request");
        mem_enable = 1'b0;
        exp_req.push_back(32'h0000_3200);
        applyStimulus(1'b1, 32'h0000_3200, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        checkOutput("mid_rst_imem_req", 32'(bus.imem_req), 32'd0);
        checkOutput("mid_rst_if_valid", 32'(bus.if_valid), 32'd0);
        checkOutput("mid_rst_imem_addr", bus.imem_addr, 32'h0000_3000);
        checkOutput("mid_rst_if_pc", bus.if_pc, 32'h0000_3000);
        exp_req.push_back(32'h0000_3000);
        rst_n           = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        tick();
        tick();
        bus.imem_rvalid = 1'b0;
        tick();
        checkOutput("late_rsp_if_valid", 32'(bus.if_valid), 32'd0);
        exp_del.push_back('{32'h0000_3000, 32'h0000_3004, 32'h1234_5678, 1'b0});
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h1234_5678;
        tick();
        bus.imem_rvalid = 1'b0;
        tick();

        checkOutput("exp_req_left", 32'(exp_req.size()), 32'd0);
        checkOutput("exp_del_left", 32'(exp_del.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch stage that owns the architectural PC register.
- Issues one instruction-memory read at a time and presents the fetched word to decode over a valid/ready handshake.
- Accepts control-flow redirects from the next-PC logic (taken branch, jal, jr).
- Sequential PC+4 advance happens internally; only redirects come from outside.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded at reset.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_BYTES, 32'h0000_4000, size of the legal fetch window in bytes.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- redirect  input  1  next-PC logic demands a non-sequential PC this cycle.
- redirect_pc  input  32  target PC, valid when redirect=1.
- imem_req  output  1  read request, one-cycle pulse.
- imem_addr  output  32  word address, equal to pc; valid with imem_req.
- imem_rvalid  input  1  read data returned; arrives at least 1 cycle after imem_req.
- imem_rdata  input  32  instruction word.
- if_valid  output  1  if_instr, if_pc, if_pc_4 and if_exc_adel are valid.
- if_ready  input  1  decode accepts the current instruction.
- if_instr  output  32  fetched instruction; 32'h0 on exception.
- if_pc  output  32  PC of if_instr.
- if_pc_4  output  32  if_pc + 4.
- if_exc_adel  output  1  fetch address error: misaligned or outside the window.

Behaviour:
- One clock domain. Reset is asynchronous and active-low, on rst_n.
- Reset values:
  - pc=RESET_PC, state=S_IDLE.
  - if_instr=0, if_pc=RESET_PC, if_pc_4=RESET_PC+4, if_exc_adel=0.
  - imem_req=0, if_valid=0.
- pc_bad = (pc[1:0]!=0) or pc<IMEM_BASE or pc>=IMEM_BASE+IMEM_BYTES. All arithmetic is 32-bit unsigned and wraps modulo 2^32.
- Combinational outputs:
  - imem_req = (state==S_ISSUE) && !pc_bad.
  - imem_addr = pc.
  - if_valid = (state==S_HOLD).
- State transitions (priority top-down within each state):
  - S_IDLE: go to S_ISSUE.
  - S_ISSUE, redirect: pc<=redirect_pc. If imem_req was 1, go to S_DROP; otherwise stay in S_ISSUE.
  - S_ISSUE, pc_bad: latch if_instr=0, if_pc=pc, if_pc_4=pc+4, if_exc_adel=1; go to S_HOLD. No memory request is made.
  - S_ISSUE, otherwise: go to S_WAIT.
  - S_WAIT, redirect && imem_rvalid: pc<=redirect_pc, response discarded, go to S_ISSUE.
  - S_WAIT, redirect && !imem_rvalid: pc<=redirect_pc, go to S_DROP.
  - S_WAIT, imem_rvalid: latch if_instr=imem_rdata, if_pc=pc, if_pc_4=pc+4, if_exc_adel=0; go to S_HOLD.
  - S_HOLD, redirect: pc<=redirect_pc, held instruction discarded (no delay slot), go to S_ISSUE. Redirect beats if_ready in the same cycle.
  - S_HOLD, if_ready: pc<=pc+4, go to S_ISSUE.
  - S_HOLD, otherwise: hold all if_* outputs stable.
  - S_DROP: redirect updates pc again and stays in S_DROP. imem_rvalid discards the data and goes to S_ISSUE. A simultaneous redirect and rvalid does both.
- Never more than one outstanding request. imem_rvalid seen in S_IDLE, S_ISSUE or S_HOLD is ignored.
- Minimum cycle count: 3 cycles per instruction with 1-cycle memory latency (ISSUE, WAIT, HOLD with if_ready=1).
- PC wrap: pc+4 from 32'hFFFF_FFFC gives 0. That PC is then flagged pc_bad, with no special-casing.
- Reset mid-request: all state clears immediately. A late imem_rvalid after reset is ignored because state is S_IDLE or S_ISSUE.

Decomposition:
- Shared package holds:
  - fetch FSM state encoding: S_IDLE, S_ISSUE, S_WAIT, S_HOLD, S_DROP, 3 bits;
  - RESET_PC and IMEM window defaults;
  - NOP constant 32'h0.
- One sub-module is natural: ifu_addr_check, combinational, computing pc_bad from pc and the parameters. It is reusable by the data-memory stage.

Test Plan:
- Reset release, 1-cycle memory, if_ready=1:
  - imem_req pulses with imem_addr=0x3000, then 0x3004, then 0x3008, one request every 3 cycles.
  - if_pc/if_pc_4 read 0x3000/0x3004, then 0x3004/0x3008.
- Backpressure: if_ready=0 for 5 cycles in S_HOLD with if_instr=0x3C01_1234.
  - Outputs stay stable and no imem_req is issued.
  - On if_ready=1 the next address is pc+4.
- Redirect in S_WAIT with 4-cycle memory latency, redirect_pc=0x3100:
  - Old response is dropped.
  - Next imem_addr=0x3100.
  - if_pc never shows the dropped PC.
- Redirect to 0x3002, then separately to 0x2FFC:
  - Each gives if_valid=1, if_exc_adel=1, if_instr=0, if_pc equal to the bad address, and no imem_req.
- Redirect and if_ready together in S_HOLD at pc=0x3010 with redirect_pc=0x3040:
  - Next imem_addr=0x3040, not 0x3014.
- rst_n asserted while in S_WAIT, with imem_rvalid arriving 1 cycle after release:
  - Data is ignored.
  - First request after reset is to 0x3000.
